input_ram_loader: RTL and testbench

Fills the 1024x1 input-image RAM that `snn_core` reads, then launches inference. It takes bytes from the UART receiver, unpacks each into 8 single-bit RAM writes at consecutive addresses, and pulses `strt` after the last bit of the image is written. It then holds off until `snn_core` reports `done`. It is the write side of the RAM port that `snn_core` reads through `addr_input_unit`/`q_input`.

---
 rtl/input_ram_loader.sv | 149 ++++++++++++++
 tb/tb_input_ram_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/input_ram_loader.sv
// Unpacks UART bytes into single-bit writes of the 1024x1 input-image RAM and launches snn_core.
// Define LOADER_MSB_FIRST_EN to write bit 7 of each byte first; default order is LSB first.
module input_ram_loader #(
    parameter int NUM_BYTES = 98,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_data,
    output logic              strt,
    output logic              busy,
    output logic              overrun
);

    localparam int BCNT_W = ADDR_W - 3;

    localparam logic [1:0] S_LOAD      = 2'd0;
    localparam logic [1:0] S_UNPACK    = 2'd1;
    localparam logic [1:0] S_START     = 2'd2;
    localparam logic [1:0] S_WAIT_CORE = 2'd3;

`ifdef LOADER_MSB_FIRST_EN
    function automatic logic first_bit(input logic [7:0] b);
        return b[7];
    endfunction
    function automatic logic [7:0] shift_bits(input logic [7:0] b);
        return {b[6:0], 1'b0};
    endfunction
`else
    function automatic logic first_bit(input logic [7:0] b);
        return b[0];
    endfunction
    function automatic logic [7:0] shift_bits(input logic [7:0] b);
        return {1'b0, b[7:1]};
    endfunction
`endif

    logic [1:0]        state;
    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] bcnt_inc;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [7:0]        hold;
    logic              hold_v;
    logic              last_bit;
    logic              last_byte;
    logic              consume;

    assign bcnt_inc  = bcnt + BCNT_W'(1);
    assign last_bit  = (bit_cnt == 3'd7);
    assign last_byte = (bcnt == BCNT_W'(NUM_BYTES - 1));
    // The hold buffer empties this cycle when it feeds the next byte without a bubble.
    assign consume   = (state == S_UNPACK) && last_bit && !last_byte && hold_v;
    assign busy      = (state != S_LOAD);

    // RAM outputs are registered one step ahead, so they hold their last value when ram_we drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_LOAD;
            bcnt     <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            hold     <= 8'd0;
            hold_v   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= 1'b0;
            strt     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            strt <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (rx_rdy) begin
                        state    <= S_UNPACK;
                        bit_cnt  <= 3'd0;
                        ram_we   <= 1'b1;
                        ram_addr <= {bcnt, 3'd0};
                        ram_data <= first_bit(rx_data);
                        shreg    <= shift_bits(rx_data);
                    end
                end
                S_UNPACK: begin
                    if (!last_bit) begin
                        bit_cnt  <= bit_cnt + 3'd1;
                        ram_addr <= {bcnt, bit_cnt + 3'd1};
                        ram_data <= first_bit(shreg);
                        shreg    <= shift_bits(shreg);
                    end else if (last_byte) begin
                        state  <= S_START;
                        ram_we <= 1'b0;
                        strt   <= 1'b1;
                    end else if (hold_v) begin
                        bcnt     <= bcnt_inc;
                        bit_cnt  <= 3'd0;
                        ram_addr <= {bcnt_inc, 3'd0};
                        ram_data <= first_bit(hold);
                        shreg    <= shift_bits(hold);
                    end else begin
                        bcnt   <= bcnt_inc;
                        state  <= S_LOAD;
                        ram_we <= 1'b0;
                    end

                    if (rx_rdy) begin
                        if (consume || !hold_v) begin
                            hold   <= rx_data;
                            hold_v <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (consume) begin
                        hold_v <= 1'b0;
                    end

                    // Anything still buffered when the image completes has nowhere to go.
                    if (last_bit && last_byte) begin
                        hold_v <= 1'b0;
                        if (hold_v || rx_rdy) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT_CORE;
                    if (rx_rdy) begin
                        overrun <= 1'b1;
                    end
                end
                S_WAIT_CORE: begin
                    if (rx_rdy) begin
                        overrun <= 1'b1;
                    end
                    if (done) begin
                        bcnt  <= '0;
                        state <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_input_ram_loader.sv
// Scoreboard bench for input_ram_loader: expected RAM writes are queued as bytes are sent.
// Honours LOADER_MSB_FIRST_EN for the expected bit order.
module tb_input_ram_loader;

    localparam int NB = 98;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          ram_data;
    logic          strt;
    logic          busy;
    logic          overrun;

    int vectors  = 0;
    int errors   = 0;
    int strt_cnt = 0;
    int base_byte = 0;
    int s0;
    logic [AW:0] exp_q[$];

    input_ram_loader #(.NUM_BYTES(NB), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_rdy   (rx_rdy),
        .rx_data  (rx_data),
        .done     (done),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .strt     (strt),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one byte for a single cycle; queues its eight writes when it should be accepted.
    task automatic applyStimulus(input logic [7:0] b, input bit accepted);
        logic eb;
        rx_data = b;
        rx_rdy  = 1'b1;
        if (accepted) begin
            for (int i = 0; i < 8; i++) begin
`ifdef LOADER_MSB_FIRST_EN
                eb = b[7-i];
`else
                eb = b[i];
`endif
                exp_q.push_back({AW'(base_byte * 8 + i), eb});
            end
            base_byte++;
        end
        tick();
        rx_rdy = 1'b0;
    endtask

    task automatic sendBytes(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'b1);
            repeat (9) tick();
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base_byte = 0;
        exp_q.delete();
    endtask

    task automatic pulseDone();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [AW:0] e;
        if (strt) strt_cnt++;
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", 32'(ram_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("write_addr", 32'(ram_addr), 32'(e[AW:1]));
                checkOutput("write_data", 32'(ram_data), 32'(e[0]));
            end
        end
    end

    initial begin
        rst     = 1'b1;
        rx_rdy  = 1'b0;
        rx_data = 8'hFF;
        done    = 1'b0;

        for (int i = 0; i < 2; i++) begin
            rx_rdy = ~rx_rdy;
            tick();
            checkOutput("rst_we",      32'(ram_we),   32'd0);
            checkOutput("rst_addr",    32'(ram_addr), 32'd0);
            checkOutput("rst_data",    32'(ram_data), 32'd0);
            checkOutput("rst_strt",    32'(strt),     32'd0);
            checkOutput("rst_busy",    32'(busy),     32'd0);
            checkOutput("rst_overrun", 32'(overrun),  32'd0);
        end
        rst    = 1'b0;
        rx_rdy = 1'b0;

        pulseDone();
        checkOutput("done_in_load_busy", 32'(busy), 32'd0);

        applyStimulus(8'hA5, 1'b1);
        checkOutput("single_busy", 32'(busy), 32'd1);
        repeat (8) tick();
        checkOutput("single_we_off",    32'(ram_we),       32'd0);
        checkOutput("single_addr_hold", 32'(ram_addr),     32'd7);
        checkOutput("single_data_hold", 32'(ram_data),     32'd1);
        checkOutput("single_idle",      32'(busy),         32'd0);
        checkOutput("single_drained",   32'(exp_q.size()), 32'd0);

        doReset();
        s0 = strt_cnt;
        sendBytes(NB - 1);
        checkOutput("image_no_early_strt", 32'(strt_cnt), 32'(s0));
        applyStimulus(8'($urandom_range(0, 255)), 1'b1);
        repeat (7) tick();
        checkOutput("image_last_we",   32'(ram_we),   32'd1);
        checkOutput("image_last_addr", 32'(ram_addr), 32'd783);
        tick();
        checkOutput("image_strt",      32'(strt),     32'd1);
        checkOutput("image_strt_busy", 32'(busy),     32'd1);
        tick();
        checkOutput("image_strt_once", 32'(strt),     32'd0);
        checkOutput("image_wait_busy", 32'(busy),     32'd1);
        checkOutput("image_strt_cnt",  32'(strt_cnt), 32'(s0 + 1));
        checkOutput("image_drained",   32'(exp_q.size()), 32'd0);

        applyStimulus(8'h3C, 1'b0);
        checkOutput("wait_overrun", 32'(overrun), 32'd1);
        repeat (3) tick();
        checkOutput("wait_no_we",   32'(ram_we),  32'd0);
        checkOutput("wait_busy",    32'(busy),    32'd1);
        pulseDone();
        checkOutput("done_busy_low", 32'(busy), 32'd0);

        base_byte = 0;
        sendBytes(NB);
        checkOutput("image2_strt_cnt", 32'(strt_cnt), 32'(s0 + 2));
        checkOutput("image2_drained",  32'(exp_q.size()), 32'd0);
        checkOutput("overrun_sticky",  32'(overrun),  32'd1);
        pulseDone();

        doReset();
        checkOutput("burst_overrun_clr", 32'(overrun), 32'd0);
        applyStimulus(8'h5A, 1'b1);
        checkOutput("burst_we_t1", 32'(ram_we), 32'd1);
        applyStimulus(8'hC3, 1'b1);
        checkOutput("burst_we_t2", 32'(ram_we), 32'd1);
        applyStimulus(8'hFF, 1'b0);
        checkOutput("burst_we_t3",   32'(ram_we),  32'd1);
        checkOutput("burst_overrun", 32'(overrun), 32'd1);
        for (int i = 4; i <= 16; i++) begin
            tick();
            checkOutput($sformatf("burst_we_t%0d", i), 32'(ram_we), 32'd1);
        end
        tick();
        checkOutput("burst_we_off",  32'(ram_we),   32'd0);
        checkOutput("burst_addr",    32'(ram_addr), 32'd15);
        checkOutput("burst_idle",    32'(busy),     32'd0);
        checkOutput("burst_drained", 32'(exp_q.size()), 32'd0);

        doReset();
        s0 = strt_cnt;
        sendBytes(40);
        doReset();
        sendBytes(NB - 1);
        checkOutput("midrst_no_early_strt", 32'(strt_cnt), 32'(s0));
        sendBytes(1);
        checkOutput("midrst_strt_cnt", 32'(strt_cnt), 32'(s0 + 1));
        checkOutput("midrst_drained",  32'(exp_q.size()), 32'd0);
        pulseDone();
        checkOutput("midrst_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
